// File: rtl/fft2d_peak_finder.sv
// Streaming peak finder for one 32x32 FFT frame (1024 row-major bins): peak magnitude, its index, count over threshold.
// Latency: result valid on the 2nd edge after the edge that captures bin 1023 (stage 1 mag, stage 2 compare, then load).
// Input is never stalled; a result still unaccepted when the next one loads is overwritten and flagged by sticky overrun.
// Optional macro SQ_MAG_EN: squared magnitude (38-bit) instead of L1 magnitude (20-bit).
module fft2d_peak_finder #(
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10,
`ifdef SQ_MAG_EN
  localparam int MAG_W    = 38
`else
  localparam int MAG_W    = 20
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic signed [18:0] in_r,
  input  logic signed [18:0] in_i,
  input  logic [MAG_W-1:0]  thresh,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [IDX_W-1:0]  peak_idx,
  output logic [10:0]       over_cnt,
  output logic              overrun,
  output logic              frm_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [MAG_W-1:0]   thr_q, thr_d;
  logic               load_q, load_d;
  logic               frm_err_q, frm_err_d;

  // Stage 1: registered magnitude and bin index.
  logic               s1_vld_q, s1_vld_d;
  logic               s1_first_q, s1_first_d;
  logic [MAG_W-1:0]   s1_mag_q, s1_mag_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;

  // Stage 2: running maximum and threshold count of the current frame.
  logic [MAG_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]   max_idx_q, max_idx_d;
  logic [10:0]        over_q, over_d;

  // Result port registers.
  logic               res_valid_q, res_valid_d;
  logic [MAG_W-1:0]   peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0]   peak_idx_q, peak_idx_d;
  logic [10:0]        over_cnt_q, over_cnt_d;
  logic               overrun_q, overrun_d;

  logic [MAG_W-1:0]   mag_c;
  logic               gt_thr;

`ifdef SQ_MAG_EN
  logic signed [37:0] r_ext, i_ext, sq_r, sq_i;

  // Squared magnitude: signed products are non-negative, so their sum fits 38 bits unsigned.
  always_comb begin
    r_ext = 38'(in_r);
    i_ext = 38'(in_i);
    sq_r  = r_ext * r_ext;
    sq_i  = i_ext * i_ext;
    mag_c = $unsigned(sq_r) + $unsigned(sq_i);
  end
`else
  logic [18:0] in_r_u, in_i_u, abs_r, abs_i;

  // L1 magnitude: two's-complement negate into 19-bit unsigned, so -2^18 maps to 2^18.
  always_comb begin
    in_r_u = $unsigned(in_r);
    in_i_u = $unsigned(in_i);
    abs_r  = in_r[18] ? (~in_r_u + 19'd1) : in_r_u;
    abs_i  = in_i[18] ? (~in_i_u + 19'd1) : in_i_u;
    mag_c  = {1'b0, abs_r} + {1'b0, abs_i};
  end
`endif

  // Frame FSM: start detection, sample counting, abort and flush sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    thr_d      = thr_q;
    load_d     = 1'b0;
    frm_err_d  = 1'b0;
    s1_vld_d   = 1'b0;
    s1_first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_ACC;
          cnt_d      = IDX_W'(1);
          thr_d      = thresh;
          s1_vld_d   = 1'b1;
          s1_first_d = 1'b1;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          s1_vld_d = 1'b1;
          cnt_d    = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_FLUSH;
          end
        end else begin
          // Short frame: drop it; the next start re-initialises stage 2.
          frm_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Any sample arriving here is ignored; IDLE picks up a still-high in_valid next cycle.
        load_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage 1 capture: the first sample of a frame is always bin 0.
  always_comb begin
    s1_mag_d = mag_c;
    s1_idx_d = (state_q == ST_IDLE) ? '0 : cnt_q;
  end

  // Stage 2: strict greater-than keeps the earliest bin on ties; first sample seeds the frame.
  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    over_d    = over_q;
    gt_thr    = (s1_mag_q > thr_q);
    if (s1_vld_q) begin
      if (s1_first_q) begin
        max_d     = s1_mag_q;
        max_idx_d = s1_idx_q;
        over_d    = {10'd0, gt_thr};
      end else begin
        if (s1_mag_q > max_q) begin
          max_d     = s1_mag_q;
          max_idx_d = s1_idx_q;
        end
        over_d = over_q + {10'd0, gt_thr};
      end
    end
  end

  // Result port: acceptance clears, a load overwrites; overrun only if the old result was not taken.
  always_comb begin
    res_valid_d = res_valid_q;
    peak_mag_d  = peak_mag_q;
    peak_idx_d  = peak_idx_q;
    over_cnt_d  = over_cnt_q;
    overrun_d   = overrun_q;
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (load_q) begin
      res_valid_d = 1'b1;
      peak_mag_d  = max_q;
      peak_idx_d  = max_idx_q;
      over_cnt_d  = over_q;
      if (res_valid_q && !res_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, pipeline and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      thr_q       <= '0;
      load_q      <= 1'b0;
      frm_err_q   <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_idx_q    <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      over_q      <= '0;
      res_valid_q <= 1'b0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      over_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      thr_q       <= thr_d;
      load_q      <= load_d;
      frm_err_q   <= frm_err_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_mag_q    <= s1_mag_d;
      s1_idx_q    <= s1_idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      over_q      <= over_d;
      res_valid_q <= res_valid_d;
      peak_mag_q  <= peak_mag_d;
      peak_idx_q  <= peak_idx_d;
      over_cnt_q  <= over_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res_valid = res_valid_q;
  assign peak_mag  = peak_mag_q;
  assign peak_idx  = peak_idx_q;
  assign over_cnt  = over_cnt_q;
  assign overrun   = overrun_q;
  assign frm_err   = frm_err_q;
  assign busy      = (state_q == ST_ACC) || (state_q == ST_FLUSH);

endmodule
